// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues credit-limited imem reads and queues in-order
// responses for decode. Optional IFETCH_PERF_EN adds fetch/flush performance counters.
module instr_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int QDEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
`ifdef IFETCH_PERF_EN
  output logic [ADDR_W-1:0] inst_pc,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_flush_cnt
`else
  output logic [ADDR_W-1:0] inst_pc
`endif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] QD_C = (CW+1)'(QDEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              started_q;
  logic [ADDR_W-1:0] pc_q   [QDEPTH];
  logic [DATA_W-1:0] data_q [QDEPTH];
  logic [QDEPTH-1:0] filled_q, filled_d;
  logic [PW-1:0]     head_q, head_d, alloc_q, alloc_d, fill_q, fill_d;
  logic [CW-1:0]     count_q, count_d, pend_q, pend_d, drop_q, drop_d;

  logic [CW:0] credit_use;
  logic        hs, pop, drop_rsp, fill_rsp;

  // Discarded responses still hold credit until they drain, so memory never sees more than QDEPTH in flight.
  assign credit_use     = {1'b0, count_q} + {1'b0, drop_q};
  assign imem_req_valid = started_q && (credit_use < QD_C);
  assign imem_req_addr  = fetch_pc_q;

  assign hs       = imem_req_valid && imem_req_ready;
  assign pop      = inst_valid && inst_ready;
  assign drop_rsp = imem_rsp_valid && (drop_q != '0);
  assign fill_rsp = imem_rsp_valid && (drop_q == '0);

  assign inst_valid = filled_q[head_q];
  assign inst_data  = inst_valid ? data_q[head_q] : '0;
  assign inst_pc    = inst_valid ? pc_q[head_q]   : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    filled_d   = filled_q;
    head_d     = head_q;
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    count_d    = count_q;
    pend_d     = pend_q;
    drop_d     = drop_q;
    if (redirect_valid) begin
      // Everything requested but not yet returned becomes a response to throw away.
      fetch_pc_d = redirect_pc;
      filled_d   = '0;
      head_d     = '0;
      alloc_d    = '0;
      fill_d     = '0;
      count_d    = '0;
      pend_d     = '0;
      drop_d     = drop_q + pend_q + CW'(hs) - CW'(imem_rsp_valid);
    end else begin
      if (hs) begin
        fetch_pc_d        = fetch_pc_q + ADDR_W'(1);
        filled_d[alloc_q] = 1'b0;
        alloc_d           = alloc_q + PW'(1);
      end
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PW'(1);
      end
      if (drop_rsp) drop_d = drop_q - CW'(1);
      if (fill_rsp) begin
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + PW'(1);
      end
      count_d = count_q + CW'(hs) - CW'(pop);
      pend_d  = pend_q + CW'(hs) - CW'(fill_rsp);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      started_q  <= 1'b0;
      filled_q   <= '0;
      head_q     <= '0;
      alloc_q    <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      pend_q     <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      started_q  <= 1'b1;
      filled_q   <= filled_d;
      head_q     <= head_d;
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
    end
  end

  // Payload storage needs no reset: outputs are masked by the filled bits.
  always_ff @(posedge clk) begin
    if (hs && !redirect_valid)       pc_q[alloc_q]  <= fetch_pc_q;
    if (fill_rsp && !redirect_valid) data_q[fill_q] <= imem_rsp_data;
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_flush_q;

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;

  // Filled entries count at the redirect; unfilled ones count later as their responses are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else if (redirect_valid) begin
      perf_flush_q <= perf_flush_q + 32'(count_q - pend_q) + 32'(imem_rsp_valid);
    end else begin
      perf_fetch_q <= perf_fetch_q + 32'(pop);
      perf_flush_q <= perf_flush_q + 32'(drop_rsp);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory model with selectable latency returning addr ^ A5A5_0000.
module tb_instr_fetch_unit;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int QD = 4;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          imem_req_valid;
  logic          imem_req_ready = 1'b1;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid = 1'b0;
  logic [DW-1:0] imem_rsp_data = '0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_pc;

  int errors = 0;
  int checks = 0;
  int lat = 1;
  int hs_cnt = 0;
  int pop_cnt = 0;
  int n;
  logic          mv [4];
  logic [AW-1:0] ma [4];
  logic [AW-1:0] exp_pc = '0;

  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .QDEPTH(QD), .RESET_PC('0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // One clock: sample at the falling edge, then update memory and expected PC just after the rising edge.
  task automatic step();
    logic          hs, pop, red;
    logic [AW-1:0] ha, rpc;
    @(negedge clk);
    if (inst_valid) begin
      chk("stream_pc", inst_pc, exp_pc);
      chk("stream_data", inst_data, exp_pc ^ K);
    end
    hs  = imem_req_valid && imem_req_ready;
    ha  = imem_req_addr;
    pop = inst_valid && inst_ready && !redirect_valid;
    red = redirect_valid;
    rpc = redirect_pc;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      mv[i] = mv[i+1];
      ma[i] = ma[i+1];
    end
    mv[3] = 1'b0;
    if (hs) begin
      mv[lat-1] = 1'b1;
      ma[lat-1] = ha;
      hs_cnt++;
    end
    imem_rsp_valid = mv[0];
    imem_rsp_data  = mv[0] ? (ma[0] ^ K) : '0;
    if (red) exp_pc = rpc;
    else if (pop) begin
      exp_pc = exp_pc + 1;
      pop_cnt++;
    end
  endtask

  task automatic wait_valid(input string tag, input int budget, output int cnt);
    cnt = 0;
    while (!inst_valid && cnt < budget) begin
      step();
      cnt++;
    end
    chk({tag, "_timeout"}, inst_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0;
      ma[i] = '0;
    end
    #1 rst = 1'b0;
    #3;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_inst_pc", inst_pc, 0);
    step();
    step();
    chk("rst_hold_req_valid", imem_req_valid, 0);

    // Stream with 1-cycle memory
    rst = 1'b1;
    inst_ready = 1'b1;
    step();
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, 0);
    chk("first_inst_valid", inst_valid, 0);
    step();
    chk("second_req_addr", imem_req_addr, 1);
    chk("fill_lat_valid", inst_valid, 0);
    step();
    chk("first_inst_vld", inst_valid, 1);
    chk("first_inst_pc", inst_pc, 0);
    chk("first_inst_data", inst_data, 32'hA5A5_0000);
    repeat (8) step();
    chk("rate_valid", inst_valid, 1);
    chk("rate_pc", inst_pc, 8);
    chk("rate_pops", pop_cnt, 8);

    // Backpressure
    inst_ready = 1'b0;
    repeat (10) step();
    chk("bp_req_valid", imem_req_valid, 0);
    chk("bp_allocated", hs_cnt - pop_cnt, QD);
    chk("bp_head_valid", inst_valid, 1);
    chk("bp_head_pc", inst_pc, 8);
    inst_ready = 1'b1;
    step();
    chk("bp_resume_req", imem_req_valid, 1);
    chk("bp_resume_valid", inst_valid, 1);
    chk("bp_resume_pc", inst_pc, 9);
    repeat (6) step();
    chk("bp_after_valid", inst_valid, 1);
    chk("bp_after_pc", inst_pc, 15);

    // Redirect with three requests in flight, 3-cycle memory
    inst_ready = 1'b0;
    lat = 3;
    repeat (10) step();
    chk("full_req_valid", imem_req_valid, 0);
    chk("full_head_valid", inst_valid, 1);
    inst_ready = 1'b1;
    repeat (3) step();
    chk("pre_redir_req_valid", imem_req_valid, 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("redir1_inst_valid", inst_valid, 0);
    chk("redir1_req_valid", imem_req_valid, 1);
    chk("redir1_req_addr", imem_req_addr, 32'h100);
    wait_valid("redir1", 12, n);
    chk("redir1_latency", n, 4);
    chk("redir1_pc", inst_pc, 32'h100);
    chk("redir1_data", inst_data, 32'hA5A5_0100);

    // Redirect coinciding with a handshake and a filling response
    step();
    chk("coinc_head_pc", inst_pc, 32'h101);
    chk("coinc_req_valid", imem_req_valid, 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk("redir2_inst_valid", inst_valid, 0);
    chk("redir2_req_valid", imem_req_valid, 1);
    chk("redir2_req_addr", imem_req_addr, 32'h200);
    wait_valid("redir2", 12, n);
    chk("redir2_latency", n, 4);
    chk("redir2_pc", inst_pc, 32'h200);
    chk("redir2_data", inst_data, 32'hA5A5_0200);

    // PC wrap
    inst_ready = 1'b0;
    repeat (10) step();
    lat = 1;
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    chk("wrap_inst_valid", inst_valid, 0);
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFE);
    wait_valid("wrap", 8, n);
    chk("wrap_latency", n, 2);
    chk("wrap_pc0", inst_pc, 32'hFFFF_FFFE);
    step();
    chk("wrap_vld1", inst_valid, 1);
    chk("wrap_pc1", inst_pc, 32'hFFFF_FFFF);
    step();
    chk("wrap_vld2", inst_valid, 1);
    chk("wrap_pc2", inst_pc, 32'h0);
    chk("wrap_data2", inst_data, 32'hA5A5_0000);
    step();
    chk("wrap_vld3", inst_valid, 1);
    chk("wrap_pc3", inst_pc, 32'h1);

    // Asynchronous reset between clock edges
    chk("pre_arst_valid", inst_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_inst_valid", inst_valid, 0);
    chk("arst_req_valid", imem_req_valid, 0);
    chk("arst_req_addr", imem_req_addr, 0);
    chk("arst_inst_pc", inst_pc, 0);
    chk("arst_inst_data", inst_data, 0);
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    exp_pc = '0;
    step();
    rst = 1'b1;
    step();
    chk("restart_req_valid", imem_req_valid, 1);
    chk("restart_req_addr", imem_req_addr, 0);
    wait_valid("restart", 8, n);
    chk("restart_latency", n, 2);
    chk("restart_pc", inst_pc, 0);
    chk("restart_data", inst_data, 32'hA5A5_0000);
    repeat (3) step();
    chk("restart_pc3", inst_pc, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Fetch-side consumer of the program counter.
- Owns the word-addressed fetch PC, which advances by 1 per accepted request.
- Issues read requests to instruction memory over a valid/ready channel and collects in-order responses into a reorder-free instruction queue.
- Presents the instructions, tagged with their PC, to decode over a valid/ready channel; branch/jump redirects flush all in-flight work.

## Interface
Parameters:
- ADDR_W, 32, PC/address width (word address)
- DATA_W, 32, instruction width
- QDEPTH, 4, instruction queue entries; power of two, ≥2
- RESET_PC, 0, fetch PC after reset

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_W  new fetch PC
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_W  word address of request
- imem_rsp_valid  in  1  read data valid (in order, one per accepted request)
- imem_rsp_data  in  DATA_W  read data
- inst_valid  out  1  head instruction valid
- inst_ready  in  1  decode consumes head
- inst_data  out  DATA_W  head instruction
- inst_pc  out  ADDR_W  PC of head instruction

## Operation
- **State:**
  - fetch_pc
  - started flag
  - QDEPTH-entry circular queue with per-entry {pc, data, filled}
  - head/alloc/fill pointers
  - drop_cnt of width $clog2(QDEPTH)+1
- **Credit:** imem_req_valid = started && (allocated entries + drop_cnt < QDEPTH); imem_req_addr = fetch_pc.
- **Request handshake** (valid && ready, no redirect):
  - allocate entry at alloc pointer with pc = fetch_pc, filled = 0
  - fetch_pc += 1, wrapping 2^ADDR_W−1 → 0
- **Response:**
  - If drop_cnt > 0: decrement drop_cnt, discard data.
  - Else: write data into the entry at the fill pointer, set filled, advance the fill pointer.
  - A response with no outstanding request is a protocol error; behaviour is undefined.
- **Output:**
  - inst_valid = head entry filled; inst_data/inst_pc come from the head entry.
  - Pop on inst_valid && inst_ready.
- **Redirect** (highest priority):
  - Clear all queue entries and pointers; fetch_pc ← redirect_pc.
  - drop_cnt ← (drop_cnt + requests allocated but unfilled + request handshake this cycle − response this cycle).
  - A response arriving in the redirect cycle is discarded.
  - A pop in the same cycle is superseded by the redirect.
  - imem_req_valid may deassert without handshake in the redirect cycle (request withdrawn); a handshake in that cycle still counts toward drop_cnt.
- **Simultaneous events:** request allocate, response fill and pop may all occur in one cycle. Occupancy is updated as +alloc −pop.
- **Full queue:** imem_req_valid is held low; no request is lost.

## Timing
- **Reset** (rst low, asynchronous):
  - fetch_pc = RESET_PC; started = 0; drop_cnt = 0; queue empty
  - imem_req_valid = 0, inst_valid = 0, inst_data = 0, inst_pc = 0
  - imem_req_addr = RESET_PC
- started sets on the first rising edge with rst high. The first request (addr RESET_PC) is visible in the following cycle.
- **Reset mid-operation:** immediate return to reset state; outstanding responses after release are not tracked (memory must also reset).
- **Request hold:** once asserted, imem_req_valid/imem_req_addr hold until handshake, except on redirect.
- **Fill latency:** response at cycle N into an empty queue gives inst_valid in cycle N+1 (registered fill).
- **Throughput:** with a 1-cycle memory and inst_ready held high, one instruction per cycle, provided QDEPTH ≥ memory latency + 2.
- **Redirect:**
  - asserted in cycle R gives inst_valid = 0 in R+1
  - the request to redirect_pc is valid in R+1 if credit allows (drop_cnt counts against credit)

## Configuration
- **IFETCH_PERF_EN:**
  - When defined, adds two output ports, perf_fetch_cnt and perf_flush_cnt (32 bits each, wrapping, reset 0).
  - perf_fetch_cnt counts instructions popped by decode.
  - perf_flush_cnt counts queue entries plus responses discarded by redirects.
  - When undefined, the ports and counters do not exist; all other behaviour is identical.

## Test plan
- **Reset/stream:** release rst, 1-cycle memory returning data = addr ^ 32'hA5A5_0000, inst_ready = 1 → instructions at pc 0,1,2,… with matching data, one per cycle after a fill latency of 3 cycles.
- **Backpressure:** inst_ready = 0 for 10 cycles → exactly QDEPTH (4) requests issued, then imem_req_valid = 0; releasing inst_ready resumes in order with no gaps or duplicates.
- **Redirect with in-flight:** 3-cycle memory latency, redirect to 0x100 while 3 requests are outstanding → those 3 responses discarded; next inst_pc = 0x100 with its data; no stale instruction ever presented.
- **Redirect + handshake + response same cycle:** all three coincide → drop_cnt accounting correct; the first delivered pc equals redirect_pc.
- **Wrap:** redirect to 32'hFFFF_FFFE → inst_pc sequence FFFF_FFFE, FFFF_FFFF, 0, 1.
- **Async reset mid-stream:** rst low between clock edges → inst_valid and imem_req_valid drop immediately; after release, fetch restarts at RESET_PC.
